// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
// PS/2 keyboard receiver. The raw kclk/kdata pins are synchronised and
// glitch-filtered, 11-bit frames are deframed with odd-parity, stop-bit and
// inter-edge timeout checks, and E0/F0 prefixes are folded into the decoded
// keycode. Keycodes are queued in a first-word-fall-through FIFO. Digit-key
// releases also write the game level register directly.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   kclk, kdata    raw PS/2 pins
//   code_data      FIFO head {ext, brk, scancode[7:0]}
//   code_valid     FIFO non-empty
//   code_ready     consumer accepts the head while code_valid is high
//   fifo_count     current FIFO occupancy
//   overflow       one-cycle pulse when a code is dropped on a full FIFO
//   parity_err     one-cycle pulse on an odd-parity failure
//   frame_err      one-cycle pulse on bad start, bad stop or timeout
//   level          selected game level
//   level_strobe   one-cycle pulse when level is written
//   dbg_state      current frame FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Handshake: a code transfers on every cycle where code_valid and code_ready
// are both high; code_valid never drops until its head entry is taken, and
// code_data is only meaningful while code_valid is high.
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8,
  parameter int LEVEL_MAX   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          kclk,
  input  logic                          kdata,
  output logic [9:0]                    code_data,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic [3:0]                    level,
  output logic                          level_strobe,
  output logic [1:0]                    dbg_state
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Input path: bit 0 is kclk, bit 1 is kdata.
  // ---------------------------------------------------------------------
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q, filt_q;
  logic       kclk_prev_q;
  logic       sample;

  assign raw = {kdata, kclk};

  for (genvar p = 0; p < 2; p++) begin : g_filt
    logic [FCW-1:0] fcnt_q;

    // The filtered pin only follows the synchroniser after FILTER_LEN
    // consecutive samples that disagree with it; any agreeing sample
    // restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q[p] <= 1'b1;
        sync2_q[p] <= 1'b1;
        filt_q[p]  <= 1'b1;
        fcnt_q     <= '0;
      end else begin
        sync1_q[p] <= raw[p];
        sync2_q[p] <= sync1_q[p];
        if (sync2_q[p] == filt_q[p]) begin
          fcnt_q <= '0;
        end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
          filt_q[p] <= sync2_q[p];
          fcnt_q    <= '0;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kclk_prev_q <= 1'b1;
    else        kclk_prev_q <= filt_q[0];
  end

  assign sample = kclk_prev_q & ~filt_q[0];

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t         state_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           par_q;
  logic [TCW-1:0] to_cnt_q;
  logic [7:0]     byte_q;
  logic           byte_valid_q;
  logic           perr_q, ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      if (sample) begin
        to_cnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!filt_q[1]) begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end else begin
              ferr_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_q <= {filt_q[1], shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= ST_PARITY;
            else                   bit_idx_q <= bit_idx_q + 1'b1;
          end
          ST_PARITY: begin
            par_q   <= filt_q[1];
            state_q <= ST_STOP;
          end
          default: begin
            state_q <= ST_IDLE;
            if (!filt_q[1]) begin
              ferr_q <= 1'b1;
            end else if (^{shift_q, par_q} == 1'b0) begin
              perr_q <= 1'b1;
            end else begin
              byte_q       <= shift_q;
              byte_valid_q <= 1'b1;
            end
          end
        endcase
      end else if (state_q != ST_IDLE) begin
        // A stalled frame is abandoned once the gap between kclk edges
        // reaches TIMEOUT_CYC cycles.
        if (to_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
          state_q  <= ST_IDLE;
          ferr_q   <= 1'b1;
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign dbg_state  = state_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

  // ---------------------------------------------------------------------
  // Prefix decoder, FIFO and level register
  // ---------------------------------------------------------------------
  logic          ext_q, brk_q;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [3:0]    level_q;
  logic          strobe_q;

  logic          is_prefix, push_req, full, pop, push_ok;
  logic [3:0]    digit;

  assign is_prefix = (byte_q == 8'hE0) || (byte_q == 8'hF0);
  assign push_req  = byte_valid_q & ~is_prefix;
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (count_q != '0) & code_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);

  always_comb begin
    digit = 4'd0;
    case (byte_q)
      8'h16:   digit = 4'd1;
      8'h1E:   digit = 4'd2;
      8'h26:   digit = 4'd3;
      8'h25:   digit = 4'd4;
      8'h2E:   digit = 4'd5;
      8'h36:   digit = 4'd6;
      8'h3D:   digit = 4'd7;
      8'h3E:   digit = 4'd8;
      8'h46:   digit = 4'd9;
      default: digit = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ext_q, brk_q, byte_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      level_q  <= 4'd1;
      strobe_q <= 1'b0;
    end else begin
      ovf_q    <= push_req & full & ~pop;
      strobe_q <= 1'b0;

      if (perr_q || ferr_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_valid_q) begin
        if (byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Level follows plain digit releases whether or not the push fit.
      if (push_req && brk_q && !ext_q && (digit != 4'd0) &&
          (digit <= 4'(LEVEL_MAX))) begin
        level_q  <= digit;
        strobe_q <= 1'b1;
      end
    end
  end

  assign code_data    = mem_q[rd_ptr_q];
  assign code_valid   = (count_q != '0);
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign level        = level_q;
  assign level_strobe = strobe_q;

endmodule
